moa_batch_sequencer: RTL and testbench

- Sequencer and controller for the combinational multi-operand adder (8 operands x 7 bits -> 9-bit sum).
- Accepts operands serially over a valid/ready stream and packs them into a register bank. The bank drives the adder inputs directly.
- Waits a programmable settle time, then captures the adder sum into a result register and returns it over a valid/ready output handshake.
- Sits between an operand producer (test driver or upstream datapath) and the shared adder instance. The adder itself stays outside this block.

---
 rtl/moa_batch_sequencer.sv | 153 +++++++++++++++
 tb/tb_moa_batch_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/moa_batch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : moa_batch_sequencer
// Description : Batch sequencer for an external combinational multi-operand
//               adder. Operands arrive one at a time over a valid/ready
//               stream and are packed into a slot bank that drives the adder
//               inputs directly. After the last operand of a batch, the block
//               waits SETTLE_CYC cycles, captures the adder sum and presents
//               it over a valid/ready result handshake.
//
// Ports       : clk        - clock, all state changes on the rising edge
//               rst        - synchronous active-high reset
//               in_valid   - operand offered
//               in_ready   - operand accepted this cycle (LOAD state only)
//               in_data    - operand value [WIDTH]
//               add_ops    - packed operands to adder, slot i at [i*WIDTH +: WIDTH]
//               add_sum    - combinational sum from adder [OUT_WIDTH]
//               res_valid  - result available
//               res_ready  - consumer takes the result
//               res_data   - captured sum [OUT_WIDTH]
//               res_ovf    - (MOA_OVF_DETECT_EN only) true sum exceeded OUT_WIDTH
//               busy       - high while settling or holding a result
//
// Options     : define MOA_OVF_DETECT_EN to add the res_ovf output and the
//               shadow accumulator that feeds it.
//
// Revision    : 1.0 - initial release
// ============================================================================
module moa_batch_sequencer #(
    parameter int WIDTH      = 7,
    parameter int NOPS       = 8,
    parameter int OUT_WIDTH  = 9,
    parameter int SETTLE_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic [NOPS*WIDTH-1:0]   add_ops,
    input  logic [OUT_WIDTH-1:0]    add_sum,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [OUT_WIDTH-1:0]    res_data,
`ifdef MOA_OVF_DETECT_EN
    output logic                    res_ovf,
`endif
    output logic                    busy
);

    localparam int c_IDX_W = (NOPS > 1) ? $clog2(NOPS) : 1;
    localparam int c_CNT_W = $clog2(SETTLE_CYC + 1);

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NOPS - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE   = c_CNT_W'(SETTLE_CYC);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_LOAD   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    logic [1:0]             r_state;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [NOPS*WIDTH-1:0]  r_slots;
    logic                   w_accept;

    assign in_ready = (r_state == c_ST_LOAD);
    assign busy     = (r_state != c_ST_LOAD);
    assign add_ops  = r_slots;
    assign w_accept = in_valid && in_ready;

`ifdef MOA_OVF_DETECT_EN
    // Wide enough to hold the exact sum of NOPS operands.
    localparam int c_ACC_W = WIDTH + c_IDX_W;

    logic [c_ACC_W-1:0] r_acc;
    logic               w_acc_hi;

    generate
        if (c_ACC_W > OUT_WIDTH) begin : g_ovf_hi
            assign w_acc_hi = |r_acc[c_ACC_W-1:OUT_WIDTH];
        end else begin : g_ovf_none
            // The adder output can never be exceeded with these widths.
            assign w_acc_hi = 1'b0;
        end
    endgenerate
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_LOAD;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_slots   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
`ifdef MOA_OVF_DETECT_EN
            r_acc     <= '0;
            res_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    if (w_accept) begin
                        r_slots[r_idx*WIDTH +: WIDTH] <= in_data;
`ifdef MOA_OVF_DETECT_EN
                        // First operand of a batch overwrites the running total.
                        if (r_idx == '0)
                            r_acc <= c_ACC_W'(in_data);
                        else
                            r_acc <= r_acc + c_ACC_W'(in_data);
`endif
                        if (r_idx == c_LAST_IDX) begin
                            r_idx   <= '0;
                            r_cnt   <= c_SETTLE;
                            r_state <= c_ST_SETTLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end

                c_ST_SETTLE: begin
                    r_cnt <= r_cnt - 1'b1;
                    // Capture on the last settle edge so res_valid rises
                    // exactly SETTLE_CYC edges after the final accept.
                    if (r_cnt == c_CNT_ONE) begin
                        res_data  <= add_sum;
                        res_valid <= 1'b1;
                        r_state   <= c_ST_DONE;
`ifdef MOA_OVF_DETECT_EN
                        res_ovf   <= w_acc_hi;
`endif
                    end
                end

                c_ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        r_state   <= c_ST_LOAD;
                    end
                end

                default: begin
                    r_state <= c_ST_LOAD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_moa_batch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_moa_batch_sequencer
// Description : Directed self-checking bench for moa_batch_sequencer. The
//               adder is modelled as the sum of all slots truncated to
//               OUT_WIDTH bits. Define MOA_OVF_DETECT_EN to also check res_ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moa_batch_sequencer;

    localparam int WIDTH      = 7;
    localparam int NOPS       = 8;
    localparam int OUT_WIDTH  = 9;
    localparam int SETTLE_CYC = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [NOPS*WIDTH-1:0]  add_ops;
    logic [OUT_WIDTH-1:0]   add_sum;
    logic                   res_valid;
    logic                   res_ready;
    logic [OUT_WIDTH-1:0]   res_data;
    logic                   busy;
`ifdef MOA_OVF_DETECT_EN
    logic                   res_ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Adder model: modulo-2^OUT_WIDTH sum of every slot.
    always_comb begin
        add_sum = '0;
        for (int i = 0; i < NOPS; i++)
            add_sum = add_sum + OUT_WIDTH'(add_ops[i*WIDTH +: WIDTH]);
    end

    moa_batch_sequencer #(
        .WIDTH      (WIDTH),
        .NOPS       (NOPS),
        .OUT_WIDTH  (OUT_WIDTH),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .add_ops   (add_ops),
        .add_sum   (add_sum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
`ifdef MOA_OVF_DETECT_EN
        .res_ovf   (res_ovf),
`endif
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand and return 1 ns after the edge that accepted it.
    task automatic send_op(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && n < 64) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_op timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_batch(input logic [NOPS*WIDTH-1:0] v);
        for (int i = 0; i < NOPS; i++)
            send_op(v[i*WIDTH +: WIDTH]);
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        while (!res_valid && n < 64) begin
            tick();
            n++;
        end
        if (!res_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_res timeout: res_valid=%0b required 1", res_valid);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        res_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %0b want 0", res_valid); end
        n_cmp++; if (res_data !== 9'd0) begin n_err++; $display("FAIL reset_res_data: got %0d want 0", res_data); end
        n_cmp++; if (add_ops !== '0) begin n_err++; $display("FAIL reset_add_ops: got %h want 0", add_ops); end
    endtask

    task automatic test_basic_stream();
        res_ready = 1'b1;
        send_batch({7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1, 7'd0});
        // One edge after the last accept.
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL stream_busy: got %0b want 1", busy); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL stream_valid_e0: got %0b want 0", res_valid); end
        tick();
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL stream_valid_e1: got %0b want 0", res_valid); end
        tick();
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid_e2: got %0b want 1", res_valid); end
        n_cmp++; if (res_data !== 9'd28) begin n_err++; $display("FAIL stream_data: got %0d want 28", res_data); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stream_in_ready_done: got %0b want 0", in_ready); end
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready_back: got %0b want 1", in_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL stream_valid_drop: got %0b want 0", res_valid); end
    endtask

    task automatic test_batches();
        logic [NOPS*WIDTH-1:0] b [3];
        logic [OUT_WIDTH-1:0]  e [3];
        b[0] = {8{7'd1}};
        e[0] = 9'd8;
        b[1] = {7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1, 7'd3};
        e[1] = 9'd31;
        b[2] = {8{7'd15}};
        e[2] = 9'd120;
        res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_batch(b[k]);
            wait_res();
            n_cmp++; if (res_data !== e[k]) begin n_err++; $display("FAIL batch%0d_data: got %0d want %0d", k, res_data, e[k]); end
`ifdef MOA_OVF_DETECT_EN
            n_cmp++; if (res_ovf !== 1'b0) begin n_err++; $display("FAIL batch%0d_ovf: got %0b want 0", k, res_ovf); end
`endif
            tick();
        end
    endtask

    task automatic test_overflow();
        res_ready = 1'b1;
        send_batch({8{7'd127}});
        wait_res();
        n_cmp++; if (res_data !== 9'd504) begin n_err++; $display("FAIL ovf_data: got %0d want 504", res_data); end
`ifdef MOA_OVF_DETECT_EN
        n_cmp++; if (res_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0b want 1", res_ovf); end
`endif
        tick();
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        send_batch({8{7'd4}});
        wait_res();
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (res_data !== 9'd32) begin n_err++; $display("FAIL bp_data c%0d: got %0d want 32", c, res_data); end
            n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid c%0d: got %0b want 1", c, res_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready c%0d: got %0b want 0", c, in_ready); end
            // One-cycle operand offer that must be ignored.
            in_valid = (c == 2);
            in_data  = 7'd99;
            tick();
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %0b want 0", res_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
        send_op(7'd9);
        n_cmp++; if (add_ops[6:0] !== 7'd9) begin n_err++; $display("FAIL bp_slot0: got %0d want 9", add_ops[6:0]); end
        n_cmp++; if (add_ops[13:7] !== 7'd4) begin n_err++; $display("FAIL bp_slot1_old: got %0d want 4", add_ops[13:7]); end
        for (int i = 1; i < NOPS; i++)
            send_op(7'd0);
        wait_res();
        n_cmp++; if (res_data !== 9'd9) begin n_err++; $display("FAIL bp_next_data: got %0d want 9", res_data); end
        tick();
    endtask

    task automatic test_reset_midbatch();
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++)
            send_op(7'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready: got %0b want 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %0b want 0", busy); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %0b want 0", res_valid); end
        n_cmp++; if (add_ops !== '0) begin n_err++; $display("FAIL mid_rst_slots: got %h want 0", add_ops); end
        send_batch({8{7'd2}});
        wait_res();
        n_cmp++; if (res_data !== 9'd16) begin n_err++; $display("FAIL mid_rst_data: got %0d want 16", res_data); end
        tick();
    endtask

    task automatic test_gaps();
        res_ready = 1'b1;
        for (int i = 0; i < NOPS; i++) begin
            send_op(7'(i + 1));
            if (i < NOPS - 1) begin
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL gap_busy op%0d: got %0b want 0", i, busy); end
                in_valid = 1'b0;
                in_data  = 7'd100;
                tick();
            end else begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL gap_busy_last: got %0b want 1", busy); end
            end
        end
        wait_res();
        n_cmp++; if (res_data !== 9'd36) begin n_err++; $display("FAIL gap_data: got %0d want 36", res_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_batches();
        test_overflow();
        test_backpressure();
        test_reset_midbatch();
        test_gaps();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
